// File: rtl/bank_read_sequencer.sv
// Bank read sequencer: turns the AGU (bank, address) index stream into one-hot
// bank reads with a broadcast word address. It realigns the returned bank data
// with its tags after the fixed bank latency. Once every issued read has drained,
// it emits a single end-of-pass pulse.
module bank_read_sequencer #(
  parameter int MA_W     = 5,
  parameter int BANK_W   = 4,
  parameter int NUM_BANK = 16,
  parameter int DATA_W   = 64,
  parameter int RD_LAT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [MA_W-1:0]            in_ma,
  input  logic [BANK_W-1:0]          in_bn,
  input  logic                       in_done,
  output logic [NUM_BANK-1:0]        bank_rd_en,
  output logic [MA_W-1:0]            bank_rd_addr,
  input  logic [NUM_BANK*DATA_W-1:0] bank_rd_data,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [BANK_W-1:0]          out_bn,
  output logic [MA_W-1:0]            out_ma,
  output logic                       out_done,
  output logic [MA_W+BANK_W:0]       rd_count,
  output logic                       busy,
  output logic                       err
);

  localparam int CNT_W = MA_W + BANK_W + 1;
  // At most RD_LAT+2 reads can be outstanding between acceptance and delivery.
  localparam int INF_W = $clog2(RD_LAT + 3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_BANK-1:0] rd_en_q, rd_en_d;
  logic [MA_W-1:0]     rd_addr_q, rd_addr_d;
  logic [BANK_W-1:0]   iss_bn_q, iss_bn_d;
  logic [RD_LAT-1:0]   tag_vld_q, tag_vld_d;
  logic [BANK_W-1:0]   tag_bn_q [RD_LAT];
  logic [BANK_W-1:0]   tag_bn_d [RD_LAT];
  logic [MA_W-1:0]     tag_ma_q [RD_LAT];
  logic [MA_W-1:0]     tag_ma_d [RD_LAT];
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [BANK_W-1:0]   out_bn_q, out_bn_d;
  logic [MA_W-1:0]     out_ma_q, out_ma_d;
  logic                out_done_q, out_done_d;
  logic [CNT_W-1:0]    rd_count_q, rd_count_d;
  logic [INF_W-1:0]    inflight_q, inflight_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                bn_ok;
  logic                can_accept;
  logic                accept;
  logic [DATA_W-1:0]   sel_data;

  // Next-state logic: accept/reject decision, issue, tag delay, data capture, pass FSM.
  always_comb begin
    bn_ok      = (32'(in_bn) < NUM_BANK);
    can_accept = (state_q == S_IDLE) || (state_q == S_ACTIVE);
    accept     = in_valid && can_accept && bn_ok;

    err_d = err_q | (in_valid && (!can_accept || !bn_ok)) | (in_done && !can_accept);

    rd_en_d   = accept ? (NUM_BANK'(1) << in_bn) : '0;
    rd_addr_d = accept ? in_ma : rd_addr_q;
    iss_bn_d  = accept ? in_bn : iss_bn_q;

    // The delay line starts at the issue register, so its tail lines up with the bank data.
    tag_vld_d    = tag_vld_q;
    tag_vld_d[0] = |rd_en_q;
    tag_bn_d[0]  = iss_bn_q;
    tag_ma_d[0]  = rd_addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_bn_d[i]  = tag_bn_q[i-1];
      tag_ma_d[i]  = tag_ma_q[i-1];
    end

    sel_data = '0;
    for (int k = 0; k < NUM_BANK; k++) begin
      if (32'(tag_bn_q[RD_LAT-1]) == k) sel_data = bank_rd_data[k*DATA_W +: DATA_W];
    end

    out_valid_d = tag_vld_q[RD_LAT-1];
    out_data_d  = out_valid_d ? sel_data : out_data_q;
    out_bn_d    = out_valid_d ? tag_bn_q[RD_LAT-1] : out_bn_q;
    out_ma_d    = out_valid_d ? tag_ma_q[RD_LAT-1] : out_ma_q;

    inflight_d = inflight_q + INF_W'(accept) - INF_W'(out_valid_q);

    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_done)       state_d = S_DRAIN;
        else if (in_valid) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (in_done) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((inflight_d == '0) && !out_valid_d) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Leaving IDLE starts a new pass, so the delivered-word count restarts there.
    rd_count_d = rd_count_q;
    if ((state_q == S_IDLE) && (state_d != S_IDLE)) rd_count_d = '0;
    else if (out_valid_d && (rd_count_q != '1))     rd_count_d = rd_count_q + CNT_W'(1);

    out_done_d = (state_d == S_DONE);
    busy_d     = (state_d == S_ACTIVE) || (state_d == S_DRAIN);
  end

  // State and registered outputs; reset abandons every in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_en_q     <= '0;
      rd_addr_q   <= '0;
      iss_bn_q    <= '0;
      tag_vld_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_bn_q[i] <= '0;
        tag_ma_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bn_q    <= '0;
      out_ma_q    <= '0;
      out_done_q  <= 1'b0;
      rd_count_q  <= '0;
      inflight_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      iss_bn_q    <= iss_bn_d;
      tag_vld_q   <= tag_vld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_bn_q[i] <= tag_bn_d[i];
        tag_ma_q[i] <= tag_ma_d[i];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bn_q    <= out_bn_d;
      out_ma_q    <= out_ma_d;
      out_done_q  <= out_done_d;
      rd_count_q  <= rd_count_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bank_rd_en   = rd_en_q;
  assign bank_rd_addr = rd_addr_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_bn       = out_bn_q;
  assign out_ma       = out_ma_q;
  assign out_done     = out_done_q;
  assign rd_count     = rd_count_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule
